// File: rtl/tiny16_intc_pkg.sv
// tiny16_intc shared definitions: config register map and controller states.
package tiny16_intc_pkg;

  localparam logic [1:0] REG_ENABLE     = 2'd0;
  localparam logic [1:0] REG_MODE       = 2'd1;
  localparam logic [1:0] REG_PENDING    = 2'd2;
  localparam logic [1:0] REG_IN_SERVICE = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } intc_state_t;

endpackage

// File: rtl/tiny16_prio_enc.sv
// Lowest-index-set-bit encoder with a valid flag; index 0 has highest priority.
module tiny16_prio_enc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         req,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     valid
);

  localparam int IDX_W = $clog2(WIDTH);

  // Scan from the top down so the lowest set bit is the last one assigned.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tiny16_intc.sv
// tiny16_intc: prioritised vectored interrupt controller with edge/level
// channels, bounded nesting with preemption and a req/ack/EOI handshake.
module tiny16_intc
  import tiny16_intc_pkg::*;
#(
  parameter int                    CHANNELS     = 8,
  parameter int                    VECTOR_WIDTH = 16,
  parameter logic [VECTOR_WIDTH-1:0] VECTOR_BASE = 16'h0000,
  parameter int                    VECTOR_SHIFT = 2,
  parameter int                    MAX_NEST     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     irq_in,
  output logic                    irq_req,
  output logic [VECTOR_WIDTH-1:0] irq_vector,
  input  logic                    irq_ack,
  input  logic                    eoi,
  output logic                    irq_active,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_addr,
  input  logic [CHANNELS-1:0]     cfg_wdata,
  output logic [CHANNELS-1:0]     cfg_rdata
);

  localparam int IDX_W = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(CHANNELS + 1);
  localparam logic [CHANNELS-1:0] ONE = CHANNELS'(1);

  logic [CHANNELS-1:0] s1, s2, s3;
  logic [CHANNELS-1:0] enable_q, mode_q, pend_q, isv_q;
  logic [CHANNELS-1:0] pend_d, isv_d, pending, edge_set;
  logic [CHANNELS-1:0] below_mask, eligible, ack_mask, eoi_mask, w1c_mask;
  logic [CNT_W-1:0]    isv_count;
  logic                nest_full;
  logic [IDX_W-1:0]    win_idx, low_idx;
  logic                win_valid, low_valid;
  logic                ack_take;

  intc_state_t             state_q, state_d;
  logic [IDX_W-1:0]        chan_q, chan_d;
  logic [VECTOR_WIDTH-1:0] vector_q, vector_d;

  // Winner among eligible channels.
  tiny16_prio_enc #(.WIDTH(CHANNELS)) u_win_enc (
    .req   (eligible),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // Lowest in-service channel: sets the preemption threshold and is what eoi retires.
  tiny16_prio_enc #(.WIDTH(CHANNELS)) u_isv_enc (
    .req   (isv_q),
    .idx   (low_idx),
    .valid (low_valid)
  );

  // Two-flop synchroniser plus a delay stage for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pending view, eligibility and the nesting limit, all from current register values.
  always_comb begin
    edge_set   = mode_q & s2 & ~s3;
    pending    = (mode_q & pend_q) | (~mode_q & s2);
    below_mask = low_valid ? ((ONE << low_idx) - ONE) : '1;
    isv_count  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      isv_count = isv_count + CNT_W'(isv_q[i]);
    end
    nest_full = (isv_count >= CNT_W'(MAX_NEST));
    eligible  = nest_full ? '0 : (pending & enable_q & below_mask);
  end

  // Next values for latched edges and in-service bits; a new edge beats any clear,
  // and eoi retires from the old in-service set before the acked bit is added.
  always_comb begin
    ack_take = (state_q == REQ) && irq_ack;
    ack_mask = ack_take ? (ONE << chan_q) : '0;
    eoi_mask = (eoi && low_valid) ? (ONE << low_idx) : '0;
    w1c_mask = (cfg_we && (cfg_addr == REG_PENDING)) ? cfg_wdata : '0;
    pend_d   = ((pend_q & ~(ack_mask | w1c_mask)) | edge_set) & mode_q;
    isv_d    = (isv_q & ~eoi_mask) | ack_mask;
  end

  // Configuration, pending and in-service registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      isv_q    <= '0;
    end else begin
      if (cfg_we && (cfg_addr == REG_ENABLE)) begin
        enable_q <= cfg_wdata;
      end
      if (cfg_we && (cfg_addr == REG_MODE)) begin
        mode_q <= cfg_wdata;
      end
      pend_q <= pend_d;
      isv_q  <= isv_d;
    end
  end

  // Request FSM: latch winner and vector in IDLE, hold them in REQ until acked.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    vector_d = vector_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d  = REQ;
          chan_d   = win_idx;
          vector_d = VECTOR_BASE + (VECTOR_WIDTH'(win_idx) << VECTOR_SHIFT);
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latched channel and vector registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      chan_q   <= '0;
      vector_q <= VECTOR_BASE;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      vector_q <= vector_d;
    end
  end

  // Zero-latency config readback.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_ENABLE:     cfg_rdata = enable_q;
      REG_MODE:       cfg_rdata = mode_q;
      REG_PENDING:    cfg_rdata = pending;
      REG_IN_SERVICE: cfg_rdata = isv_q;
      default:        cfg_rdata = '0;
    endcase
  end

  assign irq_req    = (state_q == REQ);
  assign irq_vector = vector_q;
  assign irq_active = |isv_q;

endmodule

// File: tb/tb_tiny16_intc.sv
// Self-checking bench for tiny16_intc: directed vectors, vector scoreboard.
module tb_tiny16_intc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_in = '0;
  logic        irq_req;
  logic [15:0] irq_vector;
  logic        irq_ack = 1'b0;
  logic        eoi = 1'b0;
  logic        irq_active;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [7:0]  cfg_wdata = '0;
  logic [7:0]  cfg_rdata;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic        req_seen;

  tiny16_intc #(
    .CHANNELS     (8),
    .VECTOR_WIDTH (16),
    .VECTOR_BASE  (16'h0100),
    .VECTOR_SHIFT (2),
    .MAX_NEST     (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .irq_active (irq_active),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic level);
    irq_in[ch] = level;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfgWrite(input logic [1:0] addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [7:0] data);
    cfg_addr = addr;
    #1;
    data = cfg_rdata;
  endtask

  task automatic checkReg(input string name, input logic [1:0] addr, input logic [7:0] expected);
    logic [7:0] d;
    readReg(addr, d);
    checkOutput(name, {24'h0, d}, {24'h0, expected});
  endtask

  task automatic pulseAck();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic pulseEoi();
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
  endtask

  // Counts negedges until irq_req is seen high; an expired budget is a failure.
  task automatic waitReq(input string name, input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!irq_req && cnt < budget);
    if (!irq_req) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got no irq_req within %0d cycles, want irq_req=1", name, budget);
    end
  endtask

  // Monitor: every new request is popped against the scoreboard.
  initial begin
    logic [15:0] exp_v;
    req_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (irq_req && !req_seen) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_req: got vector 0x%0h, want no request", irq_vector);
        end else begin
          exp_v = exp_q.pop_front();
          checkOutput("vector", {16'h0, irq_vector}, {16'h0, exp_v});
        end
      end
      req_seen = irq_req;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    cycles(2);
    reset = 1'b0;
    cycles(1);

    // Reset state
    checkOutput("rst_req", {31'h0, irq_req}, 32'h0);
    checkOutput("rst_vector", {16'h0, irq_vector}, 32'h0100);
    checkOutput("rst_active", {31'h0, irq_active}, 32'h0);
    checkReg("rst_enable", 2'd0, 8'h00);
    checkReg("rst_mode", 2'd1, 8'h00);
    checkReg("rst_pending", 2'd2, 8'h00);
    checkReg("rst_isv", 2'd3, 8'h00);

    cfgWrite(2'd0, 8'hFF);
    cfgWrite(2'd1, 8'hBF);
    checkReg("cfg_enable", 2'd0, 8'hFF);
    checkReg("cfg_mode", 2'd1, 8'hBF);

    // Edge on channel 3
    $display("[TB] edge channel 3");
    exp_q.push_back(16'h010C);
    applyStimulus(3, 1'b1);
    waitReq("ch3_req", 10, n);
    checkOutput("ch3_latency", n, 4);
    checkReg("ch3_pending", 2'd2, 8'h08);
    pulseAck();
    checkOutput("ch3_req_drop", {31'h0, irq_req}, 32'h0);
    checkReg("ch3_isv", 2'd3, 8'h08);
    checkReg("ch3_pend_clr", 2'd2, 8'h00);
    checkOutput("ch3_active", {31'h0, irq_active}, 32'h1);

    // Preemption by channel 1, blocking of channel 5
    $display("[TB] preemption and blocking");
    exp_q.push_back(16'h0104);
    applyStimulus(1, 1'b1);
    waitReq("ch1_req", 10, n);
    pulseAck();
    checkReg("ch1_isv", 2'd3, 8'h0A);
    applyStimulus(5, 1'b1);
    cycles(6);
    checkOutput("ch5_blocked", {31'h0, irq_req}, 32'h0);
    checkReg("ch5_pending", 2'd2, 8'h20);
    pulseEoi();
    checkReg("eoi1_isv", 2'd3, 8'h08);
    cycles(4);
    checkOutput("ch5_still_blocked", {31'h0, irq_req}, 32'h0);
    exp_q.push_back(16'h0114);
    pulseEoi();
    checkReg("eoi2_isv", 2'd3, 8'h00);
    waitReq("ch5_req", 5, n);
    checkOutput("ch5_latency", n, 1);
    pulseAck();
    checkReg("ch5_isv", 2'd3, 8'h20);
    pulseEoi();
    applyStimulus(1, 1'b0);
    applyStimulus(3, 1'b0);
    applyStimulus(5, 1'b0);
    cycles(3);

    // Nesting limit: channels 4 and 2 in service, channel 0 waits
    $display("[TB] nesting limit");
    exp_q.push_back(16'h0110);
    applyStimulus(4, 1'b1);
    waitReq("ch4_req", 10, n);
    pulseAck();
    exp_q.push_back(16'h0108);
    applyStimulus(2, 1'b1);
    waitReq("ch2_req", 10, n);
    pulseAck();
    checkReg("nest_isv", 2'd3, 8'h14);
    applyStimulus(0, 1'b1);
    cycles(6);
    checkOutput("ch0_blocked", {31'h0, irq_req}, 32'h0);
    checkReg("ch0_pending", 2'd2, 8'h01);
    exp_q.push_back(16'h0100);
    pulseEoi();
    checkReg("nest_eoi_isv", 2'd3, 8'h10);
    waitReq("ch0_req", 5, n);
    pulseAck();
    checkReg("ch0_isv", 2'd3, 8'h11);
    pulseEoi();
    pulseEoi();
    checkReg("nest_clear_isv", 2'd3, 8'h00);
    applyStimulus(0, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(4, 1'b0);
    cycles(3);

    // Level channel 6
    $display("[TB] level channel 6");
    exp_q.push_back(16'h0118);
    applyStimulus(6, 1'b1);
    waitReq("ch6_req", 10, n);
    checkOutput("ch6_latency", n, 3);
    pulseAck();
    checkReg("ch6_isv", 2'd3, 8'h40);
    cycles(3);
    checkOutput("ch6_no_rereq", {31'h0, irq_req}, 32'h0);
    exp_q.push_back(16'h0118);
    pulseEoi();
    waitReq("ch6_rereq", 5, n);
    checkOutput("ch6_rereq_latency", n, 1);
    applyStimulus(6, 1'b0);
    cycles(4);
    checkOutput("ch6_hold_req", {31'h0, irq_req}, 32'h1);
    checkOutput("ch6_hold_vector", {16'h0, irq_vector}, 32'h0118);
    pulseAck();
    pulseEoi();
    cycles(4);
    checkOutput("ch6_idle", {31'h0, irq_req}, 32'h0);

    // Write-1-to-clear against a new edge: set wins
    $display("[TB] pending clear versus new edge");
    cfgWrite(2'd0, 8'hF7);
    applyStimulus(3, 1'b1);
    cycles(4);
    checkReg("w1c_pre", 2'd2, 8'h08);
    applyStimulus(3, 1'b0);
    cycles(4);
    applyStimulus(3, 1'b1);
    cycles(2);
    cfgWrite(2'd2, 8'h08);
    checkReg("w1c_set_wins", 2'd2, 8'h08);
    cfgWrite(2'd2, 8'h08);
    checkReg("w1c_clear", 2'd2, 8'h00);
    applyStimulus(3, 1'b0);

    // eoi with nothing in service
    pulseEoi();
    checkReg("eoi_idle_isv", 2'd3, 8'h00);
    checkOutput("eoi_idle_active", {31'h0, irq_active}, 32'h0);

    // Reset during REQ
    $display("[TB] reset during request");
    exp_q.push_back(16'h0118);
    applyStimulus(6, 1'b1);
    waitReq("rst_ch6_req", 10, n);
    reset = 1'b1;
    #1;
    checkOutput("rst_async_req", {31'h0, irq_req}, 32'h0);
    checkOutput("rst_async_vector", {16'h0, irq_vector}, 32'h0100);
    checkReg("rst2_enable", 2'd0, 8'h00);
    checkReg("rst2_mode", 2'd1, 8'h00);
    checkReg("rst2_pending", 2'd2, 8'h00);
    checkReg("rst2_isv", 2'd3, 8'h00);
    applyStimulus(6, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cycles(2);

    checkOutput("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
